// File: rtl/a2d_scan_seq.sv
`timescale 1ns/1ps
// a2d_scan_seq
// Multi-channel A2D conversion sequencer with optional oversampling.
// Drives an external 16-bit SPI master through a wrt/cmd/done/rd_data handshake.
// Each conversion is two SPI transactions. The first sends the channel address,
// and its read data is thrown away. The second returns the sample.
// Supports a single-shot conversion of one channel, and a continuous
// round-robin scan of channels 0..NUM_CHNNL-1. Every result is kept in a
// per-channel buffer that can be read at any time.
//
// Parameters
//   NUM_CHNNL  channels scanned (1..8)
//   AVG_LOG2   each result is the mean of 2**AVG_LOG2 conversions (0..4)
//   INVERT     1: sample = ~rd_data[11:0], 0: sample = rd_data[11:0]
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   strt_cnv   single-shot request, sampled in IDLE only
//   chnnl      channel for single-shot
//   scan_en    level, continuous scan while high
//   busy       high whenever the sequencer is not idle
//   cnv_cmplt  sticky result-written flag, cleared by strt_cnv in IDLE
//   res        most recent averaged result
//   res_chnnl  channel that produced res
//   scan_done  1-cycle pulse after the last channel of a scan is stored
//   rd_sel     result buffer read index
//   rd_res     buffer[rd_sel] (combinational), 0 when rd_sel >= NUM_CHNNL
//   wrt        1-cycle SPI transaction start
//   cmd        SPI command {2'b00, channel, 11'h000}
//   done       SPI transaction complete pulse
//   rd_data    SPI read data, valid with done
//
// state    | meaning
// IDLE     | waiting for scan_en or strt_cnv
// CMD      | wrt pulse for the channel-address transaction
// WAIT_CMD | waiting for done of the address transaction
// PAUSE    | one idle cycle between transactions
// RD       | wrt pulse for the sample-read transaction
// WAIT_RD  | waiting for done, then accumulate the sample
// STORE    | publish the averaged result and pick the next channel
module a2d_scan_seq #(
  parameter int NUM_CHNNL = 8,
  parameter int AVG_LOG2  = 0,
  parameter bit INVERT    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        scan_en,
  output logic        busy,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic [2:0]  res_chnnl,
  output logic        scan_done,
  input  logic [2:0]  rd_sel,
  output logic [11:0] rd_res,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [2:0] LAST_CH = 3'(NUM_CHNNL - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, WAIT_CMD, PAUSE, RD, WAIT_RD, STORE
  } state_t;

  state_t           state;
  logic [2:0]       cur_ch;
  logic             scan_mode;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] smp_cnt;
  logic [11:0]      buf_mem [0:7];
  logic [11:0]      sample;
  logic [2:0]       nxt_ch;
  logic             unused_rd_hi;

  assign sample       = INVERT ? ~rd_data[11:0] : rd_data[11:0];
  assign unused_rd_hi = &{1'b0, rd_data[15:12]};

  // Next scan channel: wraps after the last scanned channel.
  assign nxt_ch = (cur_ch == LAST_CH) ? 3'd0 : cur_ch + 3'd1;

  // Entries at or above NUM_CHNNL are never written, so they stay zero,
  // but the read still masks them explicitly.
  assign rd_res = (int'(rd_sel) < NUM_CHNNL) ? buf_mem[rd_sel] : 12'h000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_ch    <= 3'd0;
      scan_mode <= 1'b0;
      acc       <= '0;
      smp_cnt   <= '0;
      busy      <= 1'b0;
      cnv_cmplt <= 1'b0;
      res       <= 12'h000;
      res_chnnl <= 3'd0;
      scan_done <= 1'b0;
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      for (int i = 0; i < 8; i++) buf_mem[i] <= 12'h000;
    end else begin
      wrt       <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (strt_cnv) cnv_cmplt <= 1'b0;
          if (scan_en) begin
            cur_ch    <= 3'd0;
            scan_mode <= 1'b1;
            cmd       <= 16'h0000;
            wrt       <= 1'b1;
            busy      <= 1'b1;
            state     <= CMD;
          end else if (strt_cnv) begin
            cur_ch    <= chnnl;
            scan_mode <= 1'b0;
            cmd       <= {2'b00, chnnl, 11'h000};
            wrt       <= 1'b1;
            busy      <= 1'b1;
            state     <= CMD;
          end
        end
        CMD: state <= WAIT_CMD;
        WAIT_CMD: if (done) state <= PAUSE;
        PAUSE: begin
          wrt   <= 1'b1;
          state <= RD;
        end
        RD: state <= WAIT_RD;
        WAIT_RD: begin
          if (done) begin
            acc <= acc + ACC_W'(sample);
            if (smp_cnt == LAST_CNT) begin
              state <= STORE;
            end else begin
              smp_cnt <= smp_cnt + CNT_W'(1);
              wrt     <= 1'b1;
              state   <= CMD;
            end
          end
        end
        STORE: begin
          res       <= acc[AVG_LOG2 +: 12];
          res_chnnl <= cur_ch;
          cnv_cmplt <= 1'b1;
          if (int'(cur_ch) < NUM_CHNNL) buf_mem[cur_ch] <= acc[AVG_LOG2 +: 12];
          acc     <= '0;
          smp_cnt <= '0;
          // A scan that reaches its last channel is complete even if scan_en
          // has just dropped.
          if (scan_mode && cur_ch == LAST_CH) scan_done <= 1'b1;
          if (scan_mode && scan_en) begin
            cur_ch <= nxt_ch;
            cmd    <= {2'b00, nxt_ch, 11'h000};
            wrt    <= 1'b1;
            state  <= CMD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_scan_seq.sv
`timescale 1ns/1ps
// Bench for a2d_scan_seq. Two instances share clk/rst_n.
//   dut_a: NUM_CHNNL=4, AVG_LOG2=0, INVERT=1 (single, reset, scan, stop, edge cases)
//   dut_b: NUM_CHNNL=8, AVG_LOG2=2, INVERT=0 (averaging)
// Each instance has an SPI slave model. The model answers a wrt pulse seen in
// cycle k with a done pulse that the DUT samples N_DLY cycles later.
module tb_a2d_scan_seq;
  localparam int N_DLY = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        strt_cnv_a, scan_en_a, busy_a, cnv_cmplt_a, scan_done_a, wrt_a, done_a;
  logic [2:0]  chnnl_a, res_chnnl_a, rd_sel_a;
  logic [11:0] res_a, rd_res_a;
  logic [15:0] cmd_a, rd_data_a;

  logic        strt_cnv_b, scan_en_b, busy_b, cnv_cmplt_b, scan_done_b, wrt_b, done_b;
  logic [2:0]  chnnl_b, res_chnnl_b, rd_sel_b;
  logic [11:0] res_b, rd_res_b;
  logic [15:0] cmd_b, rd_data_b;

  a2d_scan_seq #(.NUM_CHNNL(4), .AVG_LOG2(0), .INVERT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv_a), .chnnl(chnnl_a), .scan_en(scan_en_a),
    .busy(busy_a), .cnv_cmplt(cnv_cmplt_a), .res(res_a), .res_chnnl(res_chnnl_a),
    .scan_done(scan_done_a), .rd_sel(rd_sel_a), .rd_res(rd_res_a), .wrt(wrt_a),
    .cmd(cmd_a), .done(done_a), .rd_data(rd_data_a));

  a2d_scan_seq #(.NUM_CHNNL(8), .AVG_LOG2(2), .INVERT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv_b), .chnnl(chnnl_b), .scan_en(scan_en_b),
    .busy(busy_b), .cnv_cmplt(cnv_cmplt_b), .res(res_b), .res_chnnl(res_chnnl_b),
    .scan_done(scan_done_b), .rd_sel(rd_sel_b), .rd_res(rd_res_b), .wrt(wrt_b),
    .cmd(cmd_b), .done(done_b), .rd_data(rd_data_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SPI model for dut_a. rsp_mode 0: fixed word, 1: ~(ch*0x111), 2: ~(ch*0x111+5)
  logic        done_m_a = 1'b0, inj_done_a = 1'b0, pend_a = 1'b0;
  logic [15:0] rd_m_a = 16'h0ABC, inj_data_a = 16'h0000, rsp_fix_a = 16'h0F00;
  logic [2:0]  pend_ch_a = 3'd0;
  int          dly_a = 0, rsp_mode_a = 0, sd_cnt_a = 0;
  logic [15:0] cmd_log_a [$];

  assign done_a    = done_m_a | inj_done_a;
  assign rd_data_a = inj_done_a ? inj_data_a : rd_m_a;

  always @(negedge clk) begin
    done_m_a = 1'b0;
    rd_m_a   = 16'h0ABC;
    if (pend_a) begin
      dly_a--;
      if (dly_a == 0) begin
        pend_a   = 1'b0;
        done_m_a = 1'b1;
        case (rsp_mode_a)
          1:       rd_m_a = ~(16'(pend_ch_a) * 16'h0111);
          2:       rd_m_a = ~(16'(pend_ch_a) * 16'h0111 + 16'h0005);
          default: rd_m_a = rsp_fix_a;
        endcase
      end
    end
    if (wrt_a) begin
      pend_a    = 1'b1;
      dly_a     = N_DLY;
      pend_ch_a = cmd_a[13:11];
      cmd_log_a.push_back(cmd_a);
    end
    if (scan_done_a) sd_cnt_a++;
  end

  // SPI model for dut_b: address transactions return all ones, which must be
  // discarded. Read transactions return the sample list with junk upper bits.
  logic        done_m_b = 1'b0, pend_b = 1'b0, pend_rd_b = 1'b0;
  logic [15:0] rd_m_b = 16'h0ABC;
  logic [15:0] smp_b [4] = '{16'hF064, 16'hA065, 16'h5066, 16'h3068};
  int          dly_b = 0, wcnt_b = 0, pend_idx_b = 0, cmd_bad_b = 0;

  assign done_b    = done_m_b;
  assign rd_data_b = rd_m_b;

  always @(negedge clk) begin
    done_m_b = 1'b0;
    rd_m_b   = 16'h0ABC;
    if (pend_b) begin
      dly_b--;
      if (dly_b == 0) begin
        pend_b   = 1'b0;
        done_m_b = 1'b1;
        rd_m_b   = pend_rd_b ? smp_b[pend_idx_b % 4] : 16'hFFFF;
      end
    end
    if (wrt_b) begin
      pend_b     = 1'b1;
      dly_b      = N_DLY;
      pend_rd_b  = (wcnt_b % 2) == 1;
      pend_idx_b = wcnt_b / 2;
      if (cmd_b != 16'h0800) cmd_bad_b++;
      wcnt_b++;
    end
  end

  initial begin
    int first, cyc;
    logic [11:0] exp_buf [4];
    logic [15:0] exp_cmd;

    rst_n = 1'b0;
    strt_cnv_a = 1'b0; scan_en_a = 1'b0; chnnl_a = 3'd0; rd_sel_a = 3'd0;
    strt_cnv_b = 1'b0; scan_en_b = 1'b0; chnnl_b = 3'd0; rd_sel_b = 3'd1;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // reset state
    check("rst_busy", busy_a, 0);
    check("rst_wrt", wrt_a, 0);
    check("rst_res", res_a, 0);
    check("rst_cnv_cmplt", cnv_cmplt_a, 0);
    check("rst_cmd", cmd_a, 0);
    for (int i = 0; i < 8; i++) begin
      rd_sel_a = 3'(i);
      #1 check("rst_buf", rd_res_a, 0);
    end

    // single shot, ch3, 0x0F00 inverted -> 0x0FF, complete 2N+4 = 12 cycles
    tick(1);
    chnnl_a = 3'd3; strt_cnv_a = 1'b1;
    tick(1);
    strt_cnv_a = 1'b0;
    check("single_busy", busy_a, 1);
    first = 0; cyc = 0;
    while (first == 0 && cyc < 40) begin
      tick(1); cyc++;
      if (cnv_cmplt_a) first = cyc;
    end
    check("single_latency", first, 12);
    check("single_wrt_cnt", cmd_log_a.size(), 2);
    check("single_cmd0", cmd_log_a[0], 16'h1800);
    check("single_cmd1", cmd_log_a[1], 16'h1800);
    check("single_res", res_a, 12'h0FF);
    check("single_res_ch", res_chnnl_a, 3);
    check("single_idle", busy_a, 0);
    rd_sel_a = 3'd3;
    #1 check("single_buf3", rd_res_a, 12'h0FF);
    tick(3);
    check("single_sticky", cnv_cmplt_a, 1);

    // reset during WAIT_RD of a second single shot; its late done lands in IDLE
    chnnl_a = 3'd1; strt_cnv_a = 1'b1;
    tick(1);
    strt_cnv_a = 1'b0;
    check("clr_cnv_cmplt", cnv_cmplt_a, 0);
    tick(8);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_wrt", wrt_a, 0);
    check("mid_rst_res", res_a, 0);
    check("mid_rst_res_ch", res_chnnl_a, 0);
    check("mid_rst_cmd", cmd_a, 0);
    rd_sel_a = 3'd3;
    #1 check("mid_rst_buf3", rd_res_a, 0);
    tick(4);
    check("late_done_busy", busy_a, 0);
    check("late_done_cnv", cnv_cmplt_a, 0);

    // continuous scan
    cmd_log_a.delete();
    rsp_mode_a = 1;
    scan_en_a = 1'b1;
    cyc = 0;
    while (sd_cnt_a == 0 && cyc < 200) begin tick(1); cyc++; end
    check("scan_done_seen", sd_cnt_a, 1);
    rsp_mode_a = 2;
    check("scan_done_pulse", scan_done_a, 0);
    check("scan_res", res_a, 12'h333);
    check("scan_res_ch", res_chnnl_a, 3);
    exp_buf = '{12'h000, 12'h111, 12'h222, 12'h333};
    for (int i = 0; i < 4; i++) begin
      rd_sel_a = 3'(i);
      #1 check("scan_buf", rd_res_a, exp_buf[i]);
    end

    // drop scan_en in WAIT_CMD of ch2 on the second pass
    cyc = 0;
    while (cmd_log_a.size() < 13 && cyc < 200) begin tick(1); cyc++; end
    scan_en_a = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 100) begin tick(1); cyc++; end
    check("stop_idle", busy_a, 0);
    check("stop_no_scan_done", sd_cnt_a, 1);
    check("stop_wrt_cnt", cmd_log_a.size(), 14);
    check("stop_res_ch", res_chnnl_a, 2);
    check("stop_res", res_a, 12'h227);
    exp_buf = '{12'h005, 12'h116, 12'h227, 12'h333};
    for (int i = 0; i < 4; i++) begin
      rd_sel_a = 3'(i);
      #1 check("stop_buf", rd_res_a, exp_buf[i]);
    end
    for (int i = 0; i < cmd_log_a.size(); i++) begin
      exp_cmd = {2'b00, 3'((i / 2) % 4), 11'h000};
      check("scan_cmd_order", cmd_log_a[i], exp_cmd);
    end
    tick(20);
    check("stop_stays_idle", busy_a, 0);

    // single on ch6 (>= NUM_CHNNL); strt_cnv while busy is ignored
    cmd_log_a.delete();
    rsp_mode_a = 0; rsp_fix_a = 16'h0A5A;
    chnnl_a = 3'd6; strt_cnv_a = 1'b1;
    tick(1);
    strt_cnv_a = 1'b0;
    check("ch6_clr_cnv", cnv_cmplt_a, 0);
    tick(3);
    chnnl_a = 3'd1; strt_cnv_a = 1'b1;
    tick(1);
    strt_cnv_a = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 100) begin tick(1); cyc++; end
    check("ch6_idle", busy_a, 0);
    check("ch6_wrt_cnt", cmd_log_a.size(), 2);
    check("ch6_cmd", cmd_log_a[0], 16'h3000);
    check("ch6_res", res_a, 12'h5A5);
    check("ch6_res_ch", res_chnnl_a, 6);
    check("ch6_cnv", cnv_cmplt_a, 1);
    for (int i = 0; i < 4; i++) begin
      rd_sel_a = 3'(i);
      #1 check("ch6_buf_kept", rd_res_a, exp_buf[i]);
    end
    rd_sel_a = 3'd6;
    #1 check("rd_sel6_zero", rd_res_a, 0);
    rd_sel_a = 3'd4;
    #1 check("rd_sel4_zero", rd_res_a, 0);
    tick(5);
    check("ignored_strt_idle", busy_a, 0);

    // spurious done in IDLE
    inj_data_a = 16'h0000; inj_done_a = 1'b1;
    tick(1);
    inj_done_a = 1'b0;
    tick(3);
    check("spur_busy", busy_a, 0);
    check("spur_wrt_cnt", cmd_log_a.size(), 2);
    check("spur_res", res_a, 12'h5A5);

    // averaging on dut_b: (100+101+102+104)>>2 = 101, done at 4*(2N+3)+1 = 45
    chnnl_b = 3'd1; strt_cnv_b = 1'b1;
    tick(1);
    strt_cnv_b = 1'b0;
    first = 0; cyc = 0;
    while (first == 0 && cyc < 100) begin
      tick(1); cyc++;
      if (cnv_cmplt_b) first = cyc;
    end
    check("avg_latency", first, 45);
    check("avg_wrt_cnt", wcnt_b, 8);
    check("avg_cmd_bad", cmd_bad_b, 0);
    check("avg_res", res_b, 12'd101);
    check("avg_res_ch", res_chnnl_b, 1);
    check("avg_buf1", rd_res_b, 12'd101);
    check("avg_idle", busy_b, 0);
    check("avg_no_scan_done", scan_done_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
